regfile_scoreboard: RTL and testbench

Parametrised register file for the RISC-V pipeline. It provides NREAD read ports with same-cycle writeback bypass and a hard-wired zero register x0. A per-register pending-write scoreboard tracks in-flight long-latency writes (loads) and produces a stall request for the OF stage. The block replaces the fixed 2-read regfile array and the ad-hoc load-use forwarding mux in the top level, and gives squashed instructions an explicit way to retire their pending writes.

---
 rtl/regfile_scoreboard.sv | 161 ++++++++++++++++
 tb/tb_regfile_scoreboard.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//
// Architectural register file for the RISC-V pipeline with a per-register
// pending-write scoreboard. It replaces the fixed two-read array and the
// load-use forwarding mux that used to sit in the top level.
//
// Each register keeps a small counter of in-flight long-latency writes
// (loads). A register with a non-zero effective count is "busy". A read port
// that is in use and points at a busy register raises the OF-stage stall.
// A writeback with wb_clr retires one pending write. A kill retires one
// pending write for an instruction squashed by a flush.
//
// Ports
//   clk1        clock; every state update happens on its rising edge
//   rst         synchronous active-high reset; clears all regs and counters
//   rd_en       per-port "this read port is in use" (affects stall only)
//   rd_addr     packed read addresses, port i at [i*AW +: AW]
//   rd_data     packed read data, port i at [i*XLEN +: XLEN]
//   rd_busy     per-port: addressed register still has a pending write
//   stall       some in-use port points at a busy register
//   iss_valid   an instruction with a register destination issues
//   iss_rd      its destination register
//   iss_long    it is a long-latency write and marks iss_rd pending
//   iss_ready   a long issue to iss_rd can be accepted this cycle
//   wb_valid    writeback strobe
//   wb_rd       writeback destination
//   wb_data     writeback value
//   wb_clr      this writeback completes a long write
//   kill_valid  a long-write instruction was squashed
//   kill_rd     destination of the squashed instruction
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int NREAD    = 2,
   parameter int MAX_PEND = 3
) (
   input  logic                               clk1,
   input  logic                               rst,
   input  logic [NREAD-1:0]                   rd_en,
   input  logic [NREAD*$clog2(NREGS)-1:0]     rd_addr,
   output logic [NREAD*XLEN-1:0]              rd_data,
   output logic [NREAD-1:0]                   rd_busy,
   output logic                               stall,
   input  logic                               iss_valid,
   input  logic [$clog2(NREGS)-1:0]           iss_rd,
   input  logic                               iss_long,
   output logic                               iss_ready,
   input  logic                               wb_valid,
   input  logic [$clog2(NREGS)-1:0]           wb_rd,
   input  logic [XLEN-1:0]                    wb_data,
   input  logic                               wb_clr,
   input  logic                               kill_valid,
   input  logic [$clog2(NREGS)-1:0]           kill_rd
);

   localparam int AW = $clog2(NREGS);
   localparam int CW = $clog2(MAX_PEND + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PEND);

   // Architectural state
   logic [XLEN-1:0] regs    [NREGS];
   logic [CW-1:0]   cnt     [NREGS];

   // Counts after this cycle's retirements, and next-state counts
   logic [CW-1:0]   eff     [NREGS];
   logic [CW-1:0]   cnt_nxt [NREGS];

   // A long issue that really lands on a counter this cycle
   logic            iss_take;

   // Effective count per register: the stored count minus a completing
   // long writeback and minus a kill that target it. Each decrement is
   // skipped once the count has reached zero, which floors the result at
   // zero without needing a wider intermediate. x0 is forced to zero so a
   // stray issue, clear or kill on x0 can never make it look busy.
   always_comb begin : eff_calc
      logic [CW-1:0] e;
      for (int r = 0; r < NREGS; r++) begin
         e = cnt[r];
         if (wb_valid && wb_clr && (wb_rd == AW'(r)) && (e != '0)) begin
            e = e - CW'(1);
         end
         if (kill_valid && (kill_rd == AW'(r)) && (e != '0)) begin
            e = e - CW'(1);
         end
         eff[r] = e;
      end
      eff[0] = '0;
   end

   // A long issue is refused only when its destination would exceed the
   // per-register limit even after this cycle's retirements are counted.
   // Because a clear in the same cycle is already reflected in eff, a
   // completing load immediately frees a slot for the next one.
   always_comb begin : issue_calc
      iss_ready = ~(iss_long && (iss_rd != '0) && (eff[iss_rd] == MAX_CNT));
      iss_take  = iss_valid && iss_long && iss_ready && (iss_rd != '0);
   end

   // Next count is the effective count plus an accepted long issue. The
   // increment cannot overflow: iss_take implies eff < MAX_PEND. Issue and
   // clear on the same register therefore cancel, and issue plus clear plus
   // kill nets to one fewer pending write.
   always_comb begin : cnt_next_calc
      for (int r = 0; r < NREGS; r++) begin
         cnt_nxt[r] = eff[r];
         if (iss_take && (iss_rd == AW'(r))) begin
            cnt_nxt[r] = eff[r] + CW'(1);
         end
      end
      cnt_nxt[0] = '0;
   end

   // Read ports. x0 always reads zero. A writeback to the same register in
   // this cycle is forwarded so the consumer sees the value without waiting
   // for storage. rd_data ignores rd_en; only the stall is qualified by it.
   // Busy uses the effective count, so a load completing this cycle does not
   // stall the instruction that consumes it.
   always_comb begin : read_ports
      logic [AW-1:0] a;
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NREAD; i++) begin
         a = rd_addr[i*AW +: AW];
         if (a != '0) begin
            if (wb_valid && (wb_rd == a)) begin
               rd_data[i*XLEN +: XLEN] = wb_data;
            end else begin
               rd_data[i*XLEN +: XLEN] = regs[a];
            end
            rd_busy[i] = (eff[a] != '0);
         end
      end
   end

   // Stall request for the OF stage: any in-use port on a busy register
   always_comb begin : stall_calc
      stall = |(rd_en & rd_busy);
   end

   // State update. Reset wins over writeback, issue and kill, and throws
   // away every pending count. x0 storage is never written so it stays zero.
   always_ff @(posedge clk1) begin : state_update
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            regs[r] <= '0;
            cnt[r]  <= '0;
         end
      end else begin
         if (wb_valid && (wb_rd != '0)) begin
            regs[wb_rd] <= wb_data;
         end
         for (int r = 0; r < NREGS; r++) begin
            cnt[r] <= cnt_nxt[r];
         end
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// Self-checking bench for regfile_scoreboard. Inputs change on the falling
// edge; outputs are sampled 1 time unit later, well away from the rising
// edge where the DUT updates. A behavioural model keeps register contents
// and plain integer pending counts and predicts every output each cycle.
// Directed sequences follow the load-use, saturation, flush and reset
// scenarios, then a randomized run exercises collisions on a few registers.
// ---------------------------------------------------------------------------
module tb_regfile_scoreboard;

   localparam int XLEN     = 32;
   localparam int NREGS    = 32;
   localparam int NREAD    = 2;
   localparam int MAX_PEND = 3;
   localparam int AW       = 5;

   logic                   clk1 = 1'b0;
   logic                   rst;
   logic [NREAD-1:0]       rd_en;
   logic [NREAD*AW-1:0]    rd_addr;
   logic [NREAD*XLEN-1:0]  rd_data;
   logic [NREAD-1:0]       rd_busy;
   logic                   stall;
   logic                   iss_valid;
   logic [AW-1:0]          iss_rd;
   logic                   iss_long;
   logic                   iss_ready;
   logic                   wb_valid;
   logic [AW-1:0]          wb_rd;
   logic [XLEN-1:0]        wb_data;
   logic                   wb_clr;
   logic                   kill_valid;
   logic [AW-1:0]          kill_rd;

   int test_count = 0;
   int fail_count = 0;

   // Reference state: register values and number of outstanding long writes
   logic [XLEN-1:0] model_regs [NREGS];
   int              model_pend [NREGS];

   always #5 clk1 = ~clk1;

   regfile_scoreboard #(
      .XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .MAX_PEND(MAX_PEND)
   ) dut (
      .clk1(clk1), .rst(rst),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_busy(rd_busy), .stall(stall),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_long(iss_long),
      .iss_ready(iss_ready),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_clr(wb_clr),
      .kill_valid(kill_valid), .kill_rd(kill_rd)
   );

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [XLEN-1:0] got,
                              input logic [XLEN-1:0] exp);
      test_count++;
      if (got !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Pending writes left on register r once this cycle's clear and kill
   // are taken off, never below zero
   function automatic int model_eff(input int r);
      int e;
      e = model_pend[r];
      if (wb_valid && wb_clr && int'(wb_rd) == r) e = e - 1;
      if (kill_valid && int'(kill_rd) == r) e = e - 1;
      if (e < 0) e = 0;
      return e;
   endfunction

   function automatic logic [XLEN-1:0] model_read(input int a);
      if (a == 0) return '0;
      if (wb_valid && int'(wb_rd) == a) return wb_data;
      return model_regs[a];
   endfunction

   // Predict all outputs for the inputs currently applied
   task automatic compareModel();
      int a;
      bit exp_busy;
      bit exp_stall;
      bit exp_ready;
      exp_stall = 1'b0;
      for (int i = 0; i < NREAD; i++) begin
         a = int'(rd_addr[i*AW +: AW]);
         exp_busy = (a != 0) && (model_eff(a) != 0);
         checkOutput($sformatf("rd_data[%0d]", i), rd_data[i*XLEN +: XLEN], model_read(a));
         checkOutput($sformatf("rd_busy[%0d]", i), 32'(rd_busy[i]), 32'(exp_busy));
         if (rd_en[i] && exp_busy) exp_stall = 1'b1;
      end
      checkOutput("stall", 32'(stall), 32'(exp_stall));
      exp_ready = !(iss_long && iss_rd != '0 && model_eff(int'(iss_rd)) >= MAX_PEND);
      checkOutput("iss_ready", 32'(iss_ready), 32'(exp_ready));
   endtask

   // Advance the model by one clock edge using the inputs held across it
   task automatic updateModel();
      int nxt [NREGS];
      if (rst) begin
         for (int r = 0; r < NREGS; r++) begin
            model_regs[r] = '0;
            model_pend[r] = 0;
         end
      end else begin
         for (int r = 0; r < NREGS; r++) nxt[r] = model_eff(r);
         if (iss_valid && iss_long && iss_rd != '0 && model_eff(int'(iss_rd)) < MAX_PEND)
            nxt[iss_rd] = nxt[iss_rd] + 1;
         if (wb_valid && wb_rd != '0) model_regs[wb_rd] = wb_data;
         for (int r = 0; r < NREGS; r++) model_pend[r] = nxt[r];
      end
   endtask

   // Start a new cycle on the falling edge with every input idle
   task automatic applyStimulus();
      @(negedge clk1);
      rst        = 1'b0;
      rd_en      = '0;
      rd_addr    = '0;
      iss_valid  = 1'b0;
      iss_rd     = '0;
      iss_long   = 1'b0;
      wb_valid   = 1'b0;
      wb_rd      = '0;
      wb_data    = '0;
      wb_clr     = 1'b0;
      kill_valid = 1'b0;
      kill_rd    = '0;
   endtask

   task automatic setRead(input int port, input int addr);
      rd_addr[port*AW +: AW] = AW'(addr);
      rd_en[port] = 1'b1;
   endtask

   task automatic evaluate();
      #1;
      compareModel();
   endtask

   task automatic tick();
      @(posedge clk1);
      updateModel();
   endtask

   task automatic issueLong(input int r);
      iss_valid = 1'b1;
      iss_long  = 1'b1;
      iss_rd    = AW'(r);
   endtask

   task automatic writeBack(input int r, input logic [XLEN-1:0] d, input bit clr);
      wb_valid = 1'b1;
      wb_rd    = AW'(r);
      wb_data  = d;
      wb_clr   = clr;
   endtask

   initial begin
      for (int r = 0; r < NREGS; r++) begin
         model_regs[r] = '0;
         model_pend[r] = 0;
      end

      // Reset and idle outputs
      applyStimulus(); rst = 1'b1; evaluate(); tick();
      applyStimulus(); issueLong(1); iss_valid = 1'b0; evaluate();
      checkOutput("reset rd_data0", rd_data[31:0], 32'd0);
      checkOutput("reset stall", 32'(stall), 32'd0);
      checkOutput("reset iss_ready", 32'(iss_ready), 32'd1);
      tick();

      // Write x5, attempt x0, then read both back from storage
      applyStimulus(); writeBack(5, 32'hDEADBEEF, 1'b0); evaluate(); tick();
      applyStimulus(); writeBack(0, 32'h1234, 1'b0); setRead(1, 0); evaluate();
      checkOutput("x0 no bypass", rd_data[63:32], 32'd0);
      tick();
      applyStimulus(); setRead(0, 5); setRead(1, 0); evaluate();
      checkOutput("read x5", rd_data[31:0], 32'hDEADBEEF);
      checkOutput("read x0", rd_data[63:32], 32'd0);
      tick();

      // Same-cycle bypass, then the value from storage
      applyStimulus(); writeBack(7, 32'hA5A5A5A5, 1'b0); setRead(0, 7); evaluate();
      checkOutput("bypass x7", rd_data[31:0], 32'hA5A5A5A5);
      tick();
      applyStimulus(); setRead(0, 7); evaluate();
      checkOutput("stored x7", rd_data[31:0], 32'hA5A5A5A5);
      tick();

      // Load-use on x3
      applyStimulus(); issueLong(3); evaluate(); tick();
      applyStimulus(); setRead(0, 3); evaluate();
      checkOutput("load-use busy", 32'(rd_busy[0]), 32'd1);
      checkOutput("load-use stall", 32'(stall), 32'd1);
      tick();
      applyStimulus(); setRead(0, 3); writeBack(3, 32'h55, 1'b1); evaluate();
      checkOutput("load done busy", 32'(rd_busy[0]), 32'd0);
      checkOutput("load done stall", 32'(stall), 32'd0);
      checkOutput("load done data", rd_data[31:0], 32'h55);
      tick();

      // Saturation on x9
      for (int k = 0; k < 3; k++) begin
         applyStimulus(); issueLong(9); evaluate();
         checkOutput("sat issue ready", 32'(iss_ready), 32'd1);
         tick();
      end
      applyStimulus(); issueLong(9); evaluate();
      checkOutput("sat full", 32'(iss_ready), 32'd0);
      tick();
      applyStimulus(); issueLong(9); iss_valid = 1'b0; writeBack(9, 32'h9, 1'b1); evaluate();
      checkOutput("sat clr frees", 32'(iss_ready), 32'd1);
      tick();
      applyStimulus(); issueLong(9); evaluate();
      checkOutput("sat refill", 32'(iss_ready), 32'd1);
      tick();
      applyStimulus(); issueLong(9); evaluate();
      checkOutput("sat full again", 32'(iss_ready), 32'd0);
      tick();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(); writeBack(9, 32'h99, 1'b1); setRead(0, 9); evaluate(); tick();
      end

      // Flush: kill x4 while x6 stays pending, then kill x4 again
      applyStimulus(); issueLong(4); evaluate(); tick();
      applyStimulus(); issueLong(6); evaluate(); tick();
      applyStimulus(); kill_valid = 1'b1; kill_rd = 5'd4; setRead(0, 4); setRead(1, 6); evaluate(); tick();
      applyStimulus(); setRead(0, 4); setRead(1, 6); evaluate();
      checkOutput("flush x4 idle", 32'(rd_busy[0]), 32'd0);
      checkOutput("flush x6 busy", 32'(rd_busy[1]), 32'd1);
      tick();
      applyStimulus(); kill_valid = 1'b1; kill_rd = 5'd4; setRead(0, 4); evaluate(); tick();
      applyStimulus(); setRead(0, 4); issueLong(4); evaluate();
      checkOutput("no underflow busy", 32'(rd_busy[0]), 32'd0);
      checkOutput("no underflow ready", 32'(iss_ready), 32'd1);
      tick();
      for (int k = 0; k < 2; k++) begin
         applyStimulus(); issueLong(4); evaluate();
         checkOutput("refill x4", 32'(iss_ready), 32'd1);
         tick();
      end

      // Reset in the middle of operation
      applyStimulus(); issueLong(12); evaluate(); tick();
      applyStimulus(); issueLong(12); evaluate(); tick();
      applyStimulus(); rst = 1'b1; issueLong(12); writeBack(12, 32'hCAFE, 1'b1);
      kill_valid = 1'b1; kill_rd = 5'd6; evaluate(); tick();
      applyStimulus(); setRead(0, 12); setRead(1, 5); iss_long = 1'b1; iss_rd = 5'd12; evaluate();
      checkOutput("post-rst busy", 32'(rd_busy[0]), 32'd0);
      checkOutput("post-rst x12", rd_data[31:0], 32'd0);
      checkOutput("post-rst x5", rd_data[63:32], 32'd0);
      checkOutput("post-rst ready", 32'(iss_ready), 32'd1);
      tick();

      // Randomized traffic concentrated on x0..x7 to force collisions
      for (int n = 0; n < 600; n++) begin
         applyStimulus();
         rst        = ($urandom_range(0, 63) == 0);
         rd_en      = NREAD'($urandom);
         for (int i = 0; i < NREAD; i++) rd_addr[i*AW +: AW] = AW'($urandom_range(0, 7));
         iss_valid  = 1'($urandom_range(0, 1));
         iss_long   = ($urandom_range(0, 3) != 0);
         iss_rd     = AW'($urandom_range(0, 7));
         wb_valid   = 1'($urandom_range(0, 1));
         wb_rd      = AW'($urandom_range(0, 7));
         wb_data    = $urandom;
         wb_clr     = 1'($urandom_range(0, 1));
         kill_valid = ($urandom_range(0, 3) == 0);
         kill_rd    = AW'($urandom_range(0, 7));
         evaluate();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
